rasterizer_vertex_stream: RTL and testbench

RASTERIZER_VERTEX_STREAM -- requirements
Module: rasterizer_vertex_stream

---
 rtl/rasterizer_vertex_stream.sv | 246 ++++++++++++++++++++++++
 tb/tb_rasterizer_vertex_stream.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rasterizer_vertex_stream.sv
// Avalon-MM read master that fetches a batch of fixed-size vertices and
// streams each complete vertex downstream through a valid/ready register.
module rasterizer_vertex_stream #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32,
  parameter int WORDS      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [ADDR_W-1:0]       master_address,
  output logic                    master_read,
  output logic                    master_write,
  output logic [DATA_W/8-1:0]     master_byteenable,
  output logic [DATA_W-1:0]       master_writedata,
  input  logic                    master_waitrequest,
  input  logic [DATA_W-1:0]       master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    fetch_enable,
  input  logic [ADDR_W-1:0]       addr_in,
  input  logic [15:0]             vertex_count,
  input  logic [ADDR_W-1:0]       stride,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*DATA_W-1:0] vertex_out,
  output logic                    fetch_busy,
  output logic                    done,
  output logic                    rsp_error
);

  localparam int WI_W  = $clog2(WORDS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_L   = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [ADDR_W-1:0]       r_vbase;
  logic [ADDR_W-1:0]       r_stride;
  logic [15:0]             r_vleft;
  logic [15:0]             r_out_left;
  logic [WI_W-1:0]         r_widx;
  logic                    r_read;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [CNT_W-1:0]        r_pending;
  logic [CNT_W-1:0]        r_fcount;
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];
  logic [WORDS*DATA_W-1:0] r_asm;
  logic [WI_W-1:0]         r_asm_cnt;
  logic [WORDS*DATA_W-1:0] r_vertex;
  logic                    r_out_valid;

  logic                    w_start;
  logic                    w_accept;
  logic                    w_last_word;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_hs;
  logic                    w_asm_last;
  logic [CNT_W-1:0]        w_pend_nxt;
  logic [CNT_W-1:0]        w_fcnt_nxt;
  logic                    w_credit_ok;
  logic                    w_read_nxt;
  logic                    w_busy_nxt;
  logic                    w_done_nxt;
  logic [DATA_W-1:0]       w_fifo_rdata;
  logic [WORDS*DATA_W-1:0] w_vertex_nxt;

  assign w_start     = (r_state == IDLE) && fetch_enable;
  assign w_accept    = r_read && !master_waitrequest;
  assign w_last_word = (r_widx == LAST_WORD) && (r_vleft == 16'd1);
  // A response with nothing outstanding is stray: flag it, never store it.
  assign w_push      = master_readdatavalid && (r_pending != CNT_W'(0));
  assign w_pop       = (r_fcount != CNT_W'(0)) && (!r_out_valid || out_ready);
  assign w_hs        = r_out_valid && out_ready;
  assign w_asm_last  = w_pop && (r_asm_cnt == LAST_WORD);
  assign w_pend_nxt  = r_pending + CNT_W'(w_accept) - CNT_W'(w_push);
  assign w_fcnt_nxt  = r_fcount + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_credit_ok = ({1'b0, w_pend_nxt} + {1'b0, w_fcnt_nxt}) < DEPTH_L;
  assign w_fifo_rdata = r_mem[r_rptr];

  assign master_address    = r_addr;
  assign master_read       = r_read;
  assign master_write      = 1'b0;
  assign master_byteenable = {(DATA_W/8){1'b1}};
  assign master_writedata  = {DATA_W{1'b0}};
  assign out_valid         = r_out_valid;
  assign vertex_out        = r_vertex;
  assign fetch_busy        = r_busy;
  assign done              = r_done;
  assign rsp_error         = r_err;

  // Issue FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (fetch_enable && (vertex_count != 16'd0)) w_state_nxt = ISSUE;
        else                                         w_state_nxt = IDLE;
      end
      ISSUE: begin
        if (w_accept && w_last_word) w_state_nxt = WAIT_DRAIN;
        else                         w_state_nxt = ISSUE;
      end
      WAIT_DRAIN: begin
        if (w_hs && (r_out_left == 16'd1)) w_state_nxt = IDLE;
        else                               w_state_nxt = WAIT_DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Issue FSM outputs; a stalled request is held regardless of credit
  always_comb begin
    w_read_nxt = 1'b0;
    if (r_read && master_waitrequest) begin
      w_read_nxt = 1'b1;
    end else if (w_state_nxt == ISSUE) begin
      w_read_nxt = w_credit_ok;
    end else begin
      w_read_nxt = 1'b0;
    end
    w_busy_nxt = (w_state_nxt != IDLE) || (w_start && (vertex_count == 16'd0));
    w_done_nxt = ((r_state == WAIT_DRAIN) && (w_state_nxt == IDLE)) ||
                 (w_start && (vertex_count == 16'd0));
  end

  // Registered control outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_read <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_read <= w_read_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (master_readdatavalid && (r_pending == CNT_W'(0))) r_err <= 1'b1;
    end
  end

  // Address walk: word step of 4 bytes, vertex step by stride, both wrapping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr     <= ADDR_W'(0);
      r_vbase    <= ADDR_W'(0);
      r_stride   <= ADDR_W'(0);
      r_vleft    <= 16'd0;
      r_out_left <= 16'd0;
      r_widx     <= WI_W'(0);
    end else begin
      if (w_start) begin
        r_addr     <= addr_in;
        r_vbase    <= addr_in;
        r_stride   <= stride;
        r_vleft    <= vertex_count;
        r_out_left <= vertex_count;
        r_widx     <= WI_W'(0);
      end else begin
        if (w_accept) begin
          if (r_widx == LAST_WORD) begin
            r_addr  <= r_vbase + r_stride;
            r_vbase <= r_vbase + r_stride;
            r_widx  <= WI_W'(0);
            r_vleft <= r_vleft - 16'd1;
          end else begin
            r_addr <= r_addr + ADDR_W'(4);
            r_widx <= r_widx + WI_W'(1);
          end
        end
        if (w_hs) r_out_left <= r_out_left - 16'd1;
      end
    end
  end

  // Outstanding-read counter and read-data FIFO pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending <= CNT_W'(0);
      r_fcount  <= CNT_W'(0);
      r_wptr    <= PTR_W'(0);
      r_rptr    <= PTR_W'(0);
    end else begin
      r_pending <= w_pend_nxt;
      r_fcount  <= w_fcnt_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= master_readdata;
  end

  // Last word goes straight into the output register alongside the staged words
  always_comb begin
    w_vertex_nxt = r_asm;
    w_vertex_nxt[(WORDS-1)*DATA_W +: DATA_W] = w_fifo_rdata;
  end

  // Vertex assembler and output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_asm       <= {(WORDS*DATA_W){1'b0}};
      r_asm_cnt   <= WI_W'(0);
      r_vertex    <= {(WORDS*DATA_W){1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        if (w_asm_last) begin
          r_vertex  <= w_vertex_nxt;
          r_asm_cnt <= WI_W'(0);
        end else begin
          r_asm[r_asm_cnt*DATA_W +: DATA_W] <= w_fifo_rdata;
          r_asm_cnt <= r_asm_cnt + WI_W'(1);
        end
      end
      if (w_asm_last) r_out_valid <= 1'b1;
      else if (w_hs)  r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rasterizer_vertex_stream.sv
// Scoreboard bench: stimulus pushes expected read addresses and vertices,
// monitors pop and compare on each accepted read and each vertex handshake.
module tb_rasterizer_vertex_stream;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;

  logic                    clock;
  logic                    reset;
  logic [ADDR_W-1:0]       master_address;
  logic                    master_read;
  logic                    master_write;
  logic [DATA_W/8-1:0]     master_byteenable;
  logic [DATA_W-1:0]       master_writedata;
  logic                    master_waitrequest;
  logic [DATA_W-1:0]       master_readdata;
  logic                    master_readdatavalid;
  logic                    fetch_enable;
  logic [ADDR_W-1:0]       addr_in;
  logic [15:0]             vertex_count;
  logic [ADDR_W-1:0]       stride;
  logic                    out_valid;
  logic                    out_ready;
  logic [WORDS*DATA_W-1:0] vertex_out;
  logic                    fetch_busy;
  logic                    done;
  logic                    rsp_error;

  rasterizer_vertex_stream #(.ADDR_W(26), .DATA_W(32), .WORDS(4), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_byteenable(master_byteenable),
    .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .fetch_enable(fetch_enable), .addr_in(addr_in), .vertex_count(vertex_count),
    .stride(stride), .out_valid(out_valid), .out_ready(out_ready),
    .vertex_out(vertex_out), .fetch_busy(fetch_busy), .done(done), .rsp_error(rsp_error)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [127:0]      exp_vtx[$];
  logic [DATA_W-1:0] resp_q[$];
  int hs_cyc[$];
  bit hold = 1'b0;
  int acc_cnt = 0;
  int stall_idx = -1;
  int stall_n = 0;
  int stall_cnt = 0;
  int stall_seen = 0;
  int done_cnt = 0;
  int cyc = 0;
  logic prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = 26'd0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] data_of(input logic [25:0] a);
    return 32'hD000_0000 | {6'd0, a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: accepted reads, vertex handshakes, stall stability, done pulses
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if (prev_stall) begin
          check("hold_read", {127'd0, master_read}, 128'd1);
          check("hold_addr", {102'd0, master_address}, {102'd0, prev_addr});
        end
        if (master_read && master_waitrequest && master_address == 26'h204) stall_seen++;
        prev_stall = master_read && master_waitrequest;
        prev_addr  = master_address;
        if (master_read && !master_waitrequest) begin
          acc_cnt++;
          if (exp_addr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rd_extra actual=%h required=no read", master_address);
          end else begin
            check("rd_addr", {102'd0, master_address}, {102'd0, exp_addr.pop_front()});
          end
        end
        if (out_valid && out_ready) begin
          hs_cyc.push_back(cyc);
          if (exp_vtx.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL vtx_extra actual=%h required=no vertex", vertex_out);
          end else begin
            check("vertex", vertex_out, exp_vtx.pop_front());
          end
        end
        if (done) done_cnt++;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Slave: capture accepted requests
  initial begin
    forever begin
      @(negedge clock);
      if (reset && master_read && !master_waitrequest) resp_q.push_back(data_of(master_address));
    end
  end

  // Slave: one-cycle read latency, optional waitrequest burst on a chosen read
  initial begin
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (!hold && resp_q.size() > 0) begin
        master_readdatavalid = 1'b1;
        master_readdata = resp_q.pop_front();
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata = 32'd0;
      end
      if (master_read && acc_cnt == stall_idx && stall_cnt < stall_n) begin
        master_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        master_waitrequest = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog actual=running required=finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic start(input logic [25:0] a, input logic [15:0] n, input logic [25:0] s);
    @(posedge clock); #1;
    addr_in = a; vertex_count = n; stride = s; fetch_enable = 1'b1;
    @(posedge clock); #1;
    fetch_enable = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clock); #1;
      if (done) got = 1'b1;
    end
    if (got) begin
      check({name, "_busy_at_done"}, {127'd0, fetch_busy}, 128'd0);
    end else begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout actual=no done required=done within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clock);
    #1;
    check({name, "_addr_left"}, exp_addr.size(), 128'd0);
    check({name, "_vtx_left"}, exp_vtx.size(), 128'd0);
  endtask

  initial begin
    int d0, h0, a0;
    reset = 1'b0; fetch_enable = 1'b0; addr_in = 26'd0; vertex_count = 16'd0;
    stride = 26'd0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_read", {127'd0, master_read}, 128'd0);
    check("rst_addr", {102'd0, master_address}, 128'd0);
    check("rst_valid", {127'd0, out_valid}, 128'd0);
    check("rst_busy", {127'd0, fetch_busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_err", {127'd0, rsp_error}, 128'd0);
    check("rst_vertex", vertex_out, 128'd0);
    reset = 1'b1;

    // Two vertices, zero-wait slave
    exp_addr = '{26'h100, 26'h104, 26'h108, 26'h10C, 26'h120, 26'h124, 26'h128, 26'h12C};
    exp_vtx.push_back({32'hD000010C, 32'hD0000108, 32'hD0000104, 32'hD0000100});
    exp_vtx.push_back({32'hD000012C, 32'hD0000128, 32'hD0000124, 32'hD0000120});
    d0 = done_cnt; h0 = hs_cyc.size();
    start(26'h100, 16'd2, 26'h20);
    wait_done(100, "basic");
    check("basic_done_once", done_cnt - d0, 128'd1);
    if (hs_cyc.size() >= h0 + 2) begin
      check("throughput", hs_cyc[h0+1] - hs_cyc[h0], 128'd4);
    end else begin
      n_vec++; n_err++;
      $display("FAIL throughput actual=%0d handshakes required=2", hs_cyc.size() - h0);
    end

    // Waitrequest on the second read; a mid-batch fetch_enable must be ignored
    stall_cnt = 0; stall_n = 3; stall_seen = 0; stall_idx = acc_cnt + 1;
    exp_addr = '{26'h200, 26'h204, 26'h208, 26'h20C};
    exp_vtx.push_back({32'hD000020C, 32'hD0000208, 32'hD0000204, 32'hD0000200});
    d0 = done_cnt;
    start(26'h200, 16'd1, 26'h40);
    @(posedge clock); #1;
    addr_in = 26'h900; vertex_count = 16'd3; fetch_enable = 1'b1;
    @(posedge clock); #1;
    fetch_enable = 1'b0;
    wait_done(100, "stall");
    check("stall_cycles", stall_seen, 128'd3);
    check("stall_done_once", done_cnt - d0, 128'd1);
    stall_idx = -1;

    // Downstream blocked: register plus FIFO bound the outstanding reads
    out_ready = 1'b0;
    for (int v = 0; v < 4; v++) begin
      logic [127:0] vt;
      for (int w = 0; w < 4; w++) begin
        logic [25:0] a;
        a = 26'h400 + 26'(v * 16) + 26'(w * 4);
        exp_addr.push_back(a);
        vt[w*32 +: 32] = data_of(a);
      end
      exp_vtx.push_back(vt);
    end
    a0 = acc_cnt;
    start(26'h400, 16'd4, 26'h10);
    repeat (40) @(posedge clock);
    #1;
    check("blocked_reads", acc_cnt - a0, 128'd12);
    check("blocked_read_low", {127'd0, master_read}, 128'd0);
    check("blocked_valid", {127'd0, out_valid}, 128'd1);
    out_ready = 1'b1;
    wait_done(200, "blocked");
    check("blocked_total", acc_cnt - a0, 128'd16);

    // Address wrap at the top of the space
    exp_addr = '{26'h3FFFFF8, 26'h3FFFFFC, 26'h0000000, 26'h0000004};
    exp_vtx.push_back({32'hD0000004, 32'hD0000000, 32'hD3FFFFFC, 32'hD3FFFFF8});
    start(26'h3FFFFF8, 16'd1, 26'h40);
    wait_done(100, "wrap");

    // Empty batch
    a0 = acc_cnt;
    start(26'h80, 16'd0, 26'h20);
    check("zero_done", {127'd0, done}, 128'd1);
    check("zero_busy", {127'd0, fetch_busy}, 128'd1);
    @(posedge clock); #1;
    check("zero_done_end", {127'd0, done}, 128'd0);
    check("zero_busy_end", {127'd0, fetch_busy}, 128'd0);
    repeat (3) @(posedge clock);
    #1;
    check("zero_reads", acc_cnt - a0, 128'd0);

    // Reset with three reads outstanding, responses arrive after release
    hold = 1'b1;
    exp_addr = '{26'h600, 26'h604, 26'h608, 26'h60C};
    a0 = acc_cnt;
    start(26'h600, 16'd1, 26'h20);
    for (int i = 0; i < 20 && (acc_cnt - a0) < 3; i++) begin
      @(posedge clock); #1;
    end
    check("pre_reset_reads", acc_cnt - a0, 128'd3);
    reset = 1'b0;
    #1;
    check("async_read", {127'd0, master_read}, 128'd0);
    check("async_busy", {127'd0, fetch_busy}, 128'd0);
    exp_addr.delete();
    exp_vtx.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    hold = 1'b0;
    check("late_err_before", {127'd0, rsp_error}, 128'd0);
    repeat (8) @(posedge clock);
    #1;
    check("late_err", {127'd0, rsp_error}, 128'd1);
    check("late_valid", {127'd0, out_valid}, 128'd0);
    check("late_read", {127'd0, master_read}, 128'd0);
    check("late_resp_drained", resp_q.size(), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
